// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator sequencer: FSM state codes and default widths.
package acc_pkg;

   localparam int W_DEF  = 16;
   localparam int CW_DEF = 8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CLR  = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_ADD  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/acc_seq_cnt.sv
// Loadable down-counter holding the remaining number of additions.
module acc_seq_cnt #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] din,
   output logic [CW-1:0] q,
   output logic          zero
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (load)
         q <= din;
      else if (dec && q != '0)
         q <= q - CW'(1);
   end

   assign zero = (q == '0);

endmodule

// File: rtl/acumulador_seq.sv
// Sequencer driving a negedge accumulator to form a*b by repeated addition,
// with a wide shadow sum used only to detect overflow of the 16-bit product.
module acumulador_seq
   import acc_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  a,
   input  logic [CW-1:0] b,
   output logic          busy,
   output logic          done,
   output logic          ovf,
   output logic [W-1:0]  acc_in,
   output logic          acc_load,
   output logic          acc_clear_n,
   output logic          acc_transf
);

   logic [2:0]      state, state_nxt;
   logic [W-1:0]    a_r;
   logic [W+CW-1:0] shadow, shadow_sum;
   logic [CW-1:0]   cnt;
   logic            cnt_zero;
   logic            accept;

   assign accept     = (state == S_IDLE) && start;
   assign shadow_sum = shadow + {{CW{1'b0}}, a_r};

   acc_seq_cnt #(.CW(CW)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .dec  (state == S_ADD),
      .din  (b),
      .q    (cnt),
      .zero (cnt_zero)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CLR;
         S_CLR:   state_nxt = S_LOAD;
         S_LOAD:  state_nxt = cnt_zero ? S_DONE : S_ADD;
         S_ADD:   if (cnt == CW'(1)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control outputs are registered from the next state so they are
   // already settled when the accumulator samples on the following negedge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         a_r         <= '0;
         shadow      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ovf         <= 1'b0;
         acc_in      <= '0;
         acc_load    <= 1'b0;
         acc_transf  <= 1'b0;
         acc_clear_n <= 1'b0;
      end else begin
         state       <= state_nxt;
         busy        <= (state_nxt != S_IDLE);
         done        <= (state_nxt == S_DONE);
         acc_load    <= (state_nxt == S_LOAD);
         acc_transf  <= (state_nxt == S_ADD);
         acc_clear_n <= (state_nxt != S_CLR);
         if (state_nxt == S_LOAD || state_nxt == S_ADD)
            acc_in <= a_r;
         if (accept) begin
            a_r    <= a;
            shadow <= '0;
            ovf    <= 1'b0;
         end
         if (state == S_ADD)
            shadow <= shadow_sum;
         // The final addition lands on the same edge that enters DONE.
         if (state_nxt == S_DONE)
            ovf <= (state == S_ADD) ? |shadow_sum[W+CW-1:W] : |shadow[W+CW-1:W];
      end
   end

endmodule
